// File: rtl/product_bcd_converter_if.sv
// Handshake and result bundle between the product source and the BCD converter.
// The Blank mask exists only when PRODUCT_BCD_BLANK_EN is defined.
interface product_bcd_converter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    localparam int unsigned HALF_W = WIDTH / 2;
    localparam int unsigned BCD_W  = 4 * DIGITS;

    logic              i_start;
    logic              i_signed_mode;
    logic [HALF_W-1:0] i_aval;
    logic [HALF_W-1:0] i_bval;
    logic              o_busy;
    logic              o_done;
    logic              o_sign;
    logic [BCD_W-1:0]  o_bcd;
`ifdef PRODUCT_BCD_BLANK_EN
    logic [DIGITS-1:0] o_blank;
`endif

    modport master (
        output i_start, i_signed_mode, i_aval, i_bval,
        input  o_busy, o_done, o_sign, o_bcd
`ifdef PRODUCT_BCD_BLANK_EN
        , input o_blank
`endif
    );

    modport slave (
        input  i_start, i_signed_mode, i_aval, i_bval,
        output o_busy, o_done, o_sign, o_bcd
`ifdef PRODUCT_BCD_BLANK_EN
        , output o_blank
`endif
    );
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: {Aval,Bval} -> sign + packed BCD, one bit per clock.
// Optional leading-zero blank mask enabled by defining PRODUCT_BCD_BLANK_EN.
module product_bcd_converter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input logic                    i_clk,
    input logic                    i_rst,
    product_bcd_converter_if.slave bus
);
    localparam int unsigned HALF_W = WIDTH / 2;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned TOT_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mag;
    logic [BCD_W-1:0]   r_bcd_work;
    logic [CNT_W-1:0]   r_count;
    logic               r_sign_lat;
    logic               r_busy;
    logic               r_done;
    logic               r_sign;
    logic [BCD_W-1:0]   r_bcd;

    logic [WIDTH-1:0]   w_operand;
    logic               w_neg_req;
    logic [WIDTH-1:0]   w_mag_in;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [TOT_W-1:0]   w_shifted;
    logic [BCD_W-1:0]   w_bcd_final;

    assign w_operand = {bus.i_aval, bus.i_bval};
    assign w_neg_req = bus.i_signed_mode & bus.i_aval[HALF_W-1];
    assign w_mag_in  = w_neg_req ? WIDTH'(~w_operand + WIDTH'(1)) : w_operand;

    // Add-3 correction on every digit >= 5 ahead of the shift
    always_comb begin
        w_bcd_adj = r_bcd_work;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_bcd_work[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd_work[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted   = {w_bcd_adj, r_mag} << 1;
    assign w_bcd_final = w_shifted[TOT_W-1 -: BCD_W];

`ifdef PRODUCT_BCD_BLANK_EN
    logic [DIGITS-1:0]  r_blank;
    logic [DIGITS-1:0]  w_blank;
    logic               w_hi_zero;

    // Digit i blanks when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        w_blank   = '0;
        w_hi_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_hi_zero  = w_hi_zero & (w_bcd_final[4*i +: 4] == 4'd0);
            w_blank[i] = w_hi_zero;
        end
    end

    assign bus.o_blank = r_blank;
`endif

    // Control FSM and result registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_mag      <= '0;
            r_bcd_work <= '0;
            r_count    <= '0;
            r_sign_lat <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sign     <= 1'b0;
            r_bcd      <= '0;
`ifdef PRODUCT_BCD_BLANK_EN
            r_blank    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_mag      <= w_mag_in;
                        // A zero magnitude never reports negative
                        r_sign_lat <= w_neg_req & (|w_mag_in);
                        r_bcd_work <= '0;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd_work <= w_bcd_final;
                    r_mag      <= w_shifted[WIDTH-1:0];
                    r_count    <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sign  <= r_sign_lat;
                        r_bcd   <= w_bcd_final;
`ifdef PRODUCT_BCD_BLANK_EN
                        r_blank <= w_blank;
`endif
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_sign = r_sign;
    assign bus.o_bcd  = r_bcd;

endmodule
